// File: rtl/constants.sv
// Machine-wide constants shared by the memory-side blocks.
package constants;

  localparam int XLEN = 64;

endpackage

// File: rtl/lsu_pkg.sv
// Types and helpers shared by the load/store unit and its byte-lane datapath.
package lsu_pkg;

  import constants::*;

  localparam int kWordBytes = XLEN / 8;

  typedef enum logic [1:0] {
    SIZE_B,
    SIZE_H,
    SIZE_W,
    SIZE_D
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE,
    ACC0,
    ACC1,
    RESP
  } lsu_state_t;

  // True when an access of this size at this byte offset spills into the next word.
  function automatic logic is_split(input logic [2:0] off, input logic [1:0] size);
    return ({1'b0, off} + (4'd1 << size)) > 4'd8;
  endfunction

endpackage

// File: rtl/lsu_byte_lanes.sv
// Combinational byte-lane datapath: store merging into the memory word and
// load extraction with sign/zero extension from a two-word window.
module lsu_byte_lanes
  import constants::*;
  import lsu_pkg::*;
(
  input  logic [2:0]      off,
  input  mem_size_t       size,
  input  logic            is_unsigned,
  input  logic            sel_hi,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] old_word,
  input  logic [XLEN-1:0] load_lo,
  input  logic [XLEN-1:0] load_hi,
  output logic [XLEN-1:0] merged_word,
  output logic [XLEN-1:0] load_data
);

  logic [15:0]       base_mask;
  logic [15:0]       byte_mask;
  logic [2*XLEN-1:0] store_window;
  logic [2*XLEN-1:0] load_window;

  // Build the 16-lane mask and the store data shifted to its byte offset.
  always_comb begin
    base_mask = 16'h0000;
    case (size)
      SIZE_B:  base_mask = 16'h0001;
      SIZE_H:  base_mask = 16'h0003;
      SIZE_W:  base_mask = 16'h000F;
      default: base_mask = 16'h00FF;
    endcase
    byte_mask    = base_mask << off;
    store_window = {{XLEN{1'b0}}, wdata} << {off, 3'b000};
  end

  // Replace the selected lanes of the current memory word; sel_hi picks the upper window half.
  always_comb begin
    merged_word = old_word;
    for (int i = 0; i < kWordBytes; i++) begin
      int lane;
      lane = sel_hi ? i + kWordBytes : i;
      if (byte_mask[lane]) begin
        merged_word[i*8 +: 8] = store_window[lane*8 +: 8];
      end
    end
  end

  // Shift the two-word window down to the access offset and extend to full width.
  always_comb begin
    load_window = {load_hi, load_lo} >> {off, 3'b000};
    load_data   = '0;
    case (size)
      SIZE_B: load_data = is_unsigned ? {{(XLEN-8){1'b0}}, load_window[7:0]}
                                      : {{(XLEN-8){load_window[7]}}, load_window[7:0]};
      SIZE_H: load_data = is_unsigned ? {{(XLEN-16){1'b0}}, load_window[15:0]}
                                      : {{(XLEN-16){load_window[15]}}, load_window[15:0]};
      SIZE_W: load_data = is_unsigned ? {{(XLEN-32){1'b0}}, load_window[31:0]}
                                      : {{(XLEN-32){load_window[31]}}, load_window[31:0]};
      default: load_data = load_window[XLEN-1:0];
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Sequences byte/half/word/double loads and stores onto a doubleword-wide
// single-port memory, splitting word-crossing accesses into two cycles.
module load_store_unit
  import constants::*;
  import lsu_pkg::*;
#(
  parameter int SPLIT_MISALIGNED = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_fault,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  lsu_state_t      state;
  logic            we_q;
  mem_size_t       size_q;
  logic            unsigned_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic            split_q;
  logic            fault_q;
  logic [XLEN-1:0] word0_q;
  logic [XLEN-1:0] rdata_q;

  logic            req_split;
  logic [XLEN-1:0] base;
  logic [XLEN-1:0] merged_word;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] load_lo;

  assign req_split = is_split(req_addr[2:0], req_size);
  assign base      = {addr_q[XLEN-1:3], 3'b000};
  // In ACC0 of a non-split load both window halves are the same word; only the low bytes matter.
  assign load_lo   = (state == ACC1) ? word0_q : mem_rdata;

  lsu_byte_lanes u_lanes (
    .off         (addr_q[2:0]),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .sel_hi      (state == ACC1),
    .wdata       (wdata_q),
    .old_word    (mem_rdata),
    .load_lo     (load_lo),
    .load_hi     (mem_rdata),
    .merged_word (merged_word),
    .load_data   (load_data)
  );

  assign req_ready  = (state == IDLE) && !rst;
  assign resp_valid = (state == RESP);
  assign resp_rdata = rdata_q;
  assign resp_fault = fault_q;

  // Drive the memory port only while an access cycle is in flight.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      ACC0: begin
        mem_addr  = base;
        mem_we    = we_q;
        mem_wdata = we_q ? merged_word : '0;
      end
      ACC1: begin
        mem_addr  = base + XLEN'(kWordBytes);
        mem_we    = we_q;
        mem_wdata = we_q ? merged_word : '0;
      end
      default: ;
    endcase
  end

  // Access sequencer: latch the request, walk one or two memory cycles, hold the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      size_q     <= SIZE_B;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      split_q    <= 1'b0;
      fault_q    <= 1'b0;
      word0_q    <= '0;
      rdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q       <= req_we;
            size_q     <= mem_size_t'(req_size);
            unsigned_q <= req_unsigned;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            split_q    <= req_split;
            rdata_q    <= '0;
            if (req_split && (SPLIT_MISALIGNED == 0)) begin
              fault_q <= 1'b1;
              state   <= RESP;
            end else begin
              fault_q <= 1'b0;
              state   <= ACC0;
            end
          end
        end
        ACC0: begin
          word0_q <= mem_rdata;
          if (split_q) begin
            state <= ACC1;
          end else begin
            rdata_q <= we_q ? '0 : load_data;
            state   <= RESP;
          end
        end
        ACC1: begin
          rdata_q <= we_q ? '0 : load_data;
          state   <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            rdata_q <= '0;
            fault_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator-side access sequencer between the core's memory stage and the single-port, doubleword-organised data memory. The data memory reads combinationally, writes on the clock edge, and addresses whole `XLEN`-bit (8-byte) words only. This block converts byte/half/word/double loads and stores at arbitrary byte addresses into that interface: lane alignment, sign/zero extension, store byte merging, and splitting of word-crossing accesses into two memory cycles. The core sees a valid/ready request channel and a valid/ready response channel.

## Interface
- `SPLIT_MISALIGNED`, default 1: 1 = accesses crossing an 8-byte boundary are split into two cycles; 0 = such accesses complete with `resp_fault` and touch no memory.
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  request accepted when `req_valid && req_ready` at posedge
- `req_we`  in  1  1 = store, 0 = load
- `req_size`  in  2  0 = byte, 1 = half, 2 = word, 3 = double
- `req_unsigned`  in  1  zero-extend load result (ignored for stores and doubles)
- `req_addr`  in  `XLEN`  byte address
- `req_wdata`  in  `XLEN`  store data, right-justified
- `resp_valid`  out  1  response present
- `resp_ready`  in  1  response consumed when `resp_valid && resp_ready` at posedge
- `resp_rdata`  out  `XLEN`  load result (0 for stores and faults)
- `resp_fault`  out  1  misaligned access refused (only when `SPLIT_MISALIGNED`=0)
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  `XLEN`  memory address, bits [2:0] always 0
- `mem_wdata`  out  `XLEN`  merged store word
- `mem_rdata`  in  `XLEN`  memory read data (combinational from `mem_addr`)

## Operation
- Definitions: `nbytes` = 1 << size. `off` = addr[2:0]. `split` = `off` + `nbytes` > 8. `base` = {addr[XLEN-1:3], 3'b000}.
- The request (we, size, unsigned, addr, wdata) is latched on acceptance.
- FSM states: IDLE, ACC0, ACC1, RESP.
- IDLE
  - `req_ready`=1.
  - On acceptance: if `split` && !SPLIT_MISALIGNED, go to RESP with fault set; otherwise go to ACC0.
- ACC0
  - `mem_addr` = `base`.
  - Load: capture `mem_rdata` as word0.
  - Store: `mem_we`=1 and `mem_wdata` = `mem_rdata` with lanes [off, off+nbytes) ∩ [0,8) replaced by shifted store bytes. Read and write happen in the same cycle.
  - Next state: ACC1 if `split`, else RESP.
- ACC1
  - `mem_addr` = `base` + 8, wrapping modulo 2^XLEN.
  - Load: capture word1.
  - Store: merge the remaining high lanes into word1.
  - Next state: RESP.
- RESP
  - `resp_valid`=1.
  - Load result: the 16-byte window {word1, word0} >> (off*8), truncated to `nbytes`, then sign-extended (or zero-extended if `req_unsigned`).
  - `resp_rdata`, `resp_fault` are held stable until the handshake, then return to IDLE.
- `mem_we` is 1 only in ACC0/ACC1 for stores. `mem_addr`, `mem_wdata` are 0 outside ACC0/ACC1.
- A new request is not accepted in the RESP cycle: at most one access is outstanding.

## Timing
- All outputs are decoded from registered state and latched request; there are no combinational paths from `req_*` to `mem_*` or `resp_*`.
- Latency from the acceptance edge to first `resp_valid`:
  - 2 cycles for a non-split access.
  - 3 cycles for a split access.
  - 1 cycle for a fault.
- Throughput: one access per 3 (non-split) or 4 (split) cycles with `resp_ready` tied high.
- Reset (asynchronous) returns the FSM to IDLE immediately.
  - While `rst`=1: `req_ready`=0, `resp_valid`=0, `resp_fault`=0, `resp_rdata`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - Reset during ACC1 of a split store leaves word0 already written. There is no rollback.
- `resp_ready` may be high before `resp_valid`. The handshake completes on the first RESP cycle.

## Structure
- Shared package `lsu_pkg`:
  - `mem_size_t` enum (SIZE_B, SIZE_H, SIZE_W, SIZE_D).
  - `lsu_state_t` enum (IDLE, ACC0, ACC1, RESP).
  - `kWordBytes` = `XLEN`/8.
- `XLEN` comes from `constants.sv`.
- One sub-module, `lsu_byte_lanes` (combinational), contains:
  - 16-bit byte-mask generation.
  - Store-data shift into a 128-bit window.
  - Per-lane merge of the two words.
  - Load-side window extract and extension.
- The FSM and registers stay in `load_store_unit`.

## Test plan
- LD 0x10, memory[0x10]=0x1122334455667788, `resp_ready`=1 → `resp_valid` 2 cycles after acceptance, `resp_rdata`=0x1122334455667788, `mem_we` never 1.
- LB 0x17, memory[0x10]=0x80FF…FF → `resp_rdata`=0xFFFFFFFFFFFFFF80. Same as LBU → 0x0000000000000080.
- SH 0x0B, `req_wdata`=0xBEEF, memory[0x08]=0 → memory[0x08]=0x000000BEEF000000, one `mem_we` cycle, latency 2.
- SD 0x0C, data 0x0102030405060708, memory[0x08] and memory[0x10] = all-ones:
  - memory[0x08]=0x05060708FFFFFFFF and memory[0x10]=0xFFFFFFFF01020304.
  - Latency 3.
  - A following LD 0x0C returns 0x0102030405060708.
- `SPLIT_MISALIGNED`=0, LW 0x06 → `resp_fault`=1 and `resp_rdata`=0 one cycle after acceptance, `mem_we`=0 and `mem_addr`=0 throughout.
- Backpressure and reset:
  - `resp_ready`=0 for 5 cycles → `resp_valid`, `resp_rdata` stable; `req_ready`=0.
  - Separately, `rst` pulsed during ACC1 of the split SD above → all outputs 0 immediately, memory[0x08] updated, memory[0x10] unchanged, next request accepted normally.
